// File: rtl/pipe_trace_buffer_pkg.sv
// ----------------------------------------------------------------------------
// pipe_trace_buffer_pkg
//   Shared definitions for the pipeline trace recorder: capture-FSM state
//   encodings, stage index names (F..W, F is the LSB slice of the flattened
//   stage word bus) and the trace entry width calculation.
//   Optional feature macro: PIPE_TRACE_TIMESTAMP_EN (adds a TS_W timestamp
//   as the MSBs of every entry).
// ----------------------------------------------------------------------------
package pipe_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

    // Stage slice index within stage_ir, fetch first.
    typedef enum int {
        STG_F = 0,
        STG_D = 1,
        STG_E = 2,
        STG_M = 3,
        STG_W = 4
    } stage_idx_t;

`ifdef PIPE_TRACE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    // Entry layout is {[ts], fwd_sel, stall, stage_ir}.
    function automatic int entry_width(input int stages, input int iw,
                                       input int fwd_w, input int ts_w);
        return fwd_w + 1 + stages * iw + (TS_ON ? ts_w : 0);
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// ----------------------------------------------------------------------------
// pipe_trace_buffer_ram
//   DEPTH x WIDTH trace storage with one synchronous write port and one
//   synchronous read port. The storage array has no reset; only the read
//   data register is cleared so the buffer presents zero after reset.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high, clears rdata only
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (rdata updates on the next edge)
//   raddr  in   read address
//   rdata  out  registered read data
// ----------------------------------------------------------------------------
module pipe_trace_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 176,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// ----------------------------------------------------------------------------
// pipe_trace_buffer
//   Per-cycle trace recorder for the 5-stage core. Records every qualified
//   cycle's stage instruction words, stall and forward selects into a
//   circular buffer, freezes a window around a masked-compare trigger and
//   drains the frozen window oldest-first over a 1-cycle-latency read port.
//   Observation only; nothing here drives the core.
//   Optional feature macro: PIPE_TRACE_TIMESTAMP_EN (free-running cycle
//   counter prepended to each entry).
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   arm         pulse: clear buffer and start recording (ARMED)
//   cap_en      cycle qualifier, 0 = cycle not recorded
//   stage_ir    flattened stage instruction words, F in the LSBs
//   stall       core stall
//   fwd_sel     forward MUX selects
//   trig_val    trigger compare value
//   trig_msk    trigger compare mask (1 = bit compared)
//   trig_stg    stage whose word is compared
//   rd_req      request next oldest entry (FROZEN only)
//   rd_valid    rd_data valid (1-cycle pulse)
//   rd_data     {[ts], fwd_sel, stall, stage_ir}
//   rd_empty    no unread entries
//   frozen      capture window frozen
//   count       valid entries, saturates at DEPTH
// ----------------------------------------------------------------------------
module pipe_trace_buffer
    import pipe_trace_buffer_pkg::*;
#(
    parameter int  STAGES    = 5,
    parameter int  IW        = 32,
    parameter int  FWD_W     = 15,
    parameter int  DEPTH     = 16,
    parameter int  POST_TRIG = 8,
    parameter int  TS_W      = 16,
    localparam int TSG_W     = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int ENTRY_W   = entry_width(STAGES, IW, FWD_W, TS_W),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 cap_en,
    input  logic [STAGES*IW-1:0] stage_ir,
    input  logic                 stall,
    input  logic [FWD_W-1:0]     fwd_sel,
    input  logic [IW-1:0]        trig_val,
    input  logic [IW-1:0]        trig_msk,
    input  logic [TSG_W-1:0]     trig_stg,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [ENTRY_W-1:0]   rd_data,
    output logic                 rd_empty,
    output logic                 frozen,
    output logic [CW-1:0]        count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
    localparam int              PT_M1     = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;
    localparam logic [AW-1:0]   POST_LAST = AW'(PT_M1);

    trace_state_t       state;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      post_cnt;

    logic [IW-1:0]      trig_word_p0;
    logic               trig_stg_ok_p0;
    logic               trig_hit_p0;
    logic               capture_p0;
    logic               rd_accept_p0;
    logic [AW-1:0]      rd_addr_p0;
    logic [ENTRY_W-1:0] entry_p0;

    // ---- stage p0: entry assembly, trigger compare, request qualification ----
`ifdef PIPE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign entry_p0 = {ts, fwd_sel, stall, stage_ir};
`else
    assign entry_p0 = {fwd_sel, stall, stage_ir};
`endif

    // An out-of-range stage index selects nothing, so it can never match
    // even with an all-zero mask.
    always_comb begin
        trig_word_p0   = '0;
        trig_stg_ok_p0 = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (int'(trig_stg) == i) begin
                trig_word_p0   = stage_ir[i*IW +: IW];
                trig_stg_ok_p0 = 1'b1;
            end
        end
    end

    assign trig_hit_p0  = trig_stg_ok_p0 &&
                          (((trig_word_p0 ^ trig_val) & trig_msk) == '0);

    // arm takes priority over both capture and readout in the same cycle.
    assign capture_p0   = !arm && cap_en &&
                          (state == ST_ARMED || state == ST_POST);
    assign rd_accept_p0 = !arm && rd_req && (state == ST_FROZEN) &&
                          (count != '0);

    // Oldest entry; with a full buffer count[AW-1:0] is 0 so this is wr_ptr.
    assign rd_addr_p0   = wr_ptr - count[AW-1:0];

    // ---- stage p1: control state, buffer write, registered read ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            rd_valid <= 1'b0;
            rd_empty <= 1'b1;
            frozen   <= 1'b0;
        end else begin
            rd_valid <= rd_accept_p0;
            if (arm) begin
                state    <= ST_ARMED;
                wr_ptr   <= '0;
                count    <= '0;
                post_cnt <= '0;
                rd_empty <= 1'b1;
                frozen   <= 1'b0;
            end else begin
                if (capture_p0) begin
                    wr_ptr   <= wr_ptr + AW'(1);
                    rd_empty <= 1'b0;
                    if (count != FULL) begin
                        count <= count + CW'(1);
                    end
                end
                case (state)
                    ST_ARMED: begin
                        if (capture_p0 && trig_hit_p0) begin
                            if (POST_TRIG == 0) begin
                                state  <= ST_FROZEN;
                                frozen <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (capture_p0) begin
                            post_cnt <= post_cnt + AW'(1);
                            if (post_cnt == POST_LAST) begin
                                state  <= ST_FROZEN;
                                frozen <= 1'b1;
                            end
                        end
                    end
                    ST_FROZEN: begin
                        if (rd_accept_p0) begin
                            count    <= count - CW'(1);
                            rd_empty <= (count == CW'(1));
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    pipe_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clk   (clk),
        .reset (reset),
        .we    (capture_p0),
        .waddr (wr_ptr),
        .wdata (entry_p0),
        .re    (rd_accept_p0),
        .raddr (rd_addr_p0),
        .rdata (rd_data)
    );

endmodule
